aes_cp_host: RTL and testbench

- Bus-initiator front end for the aes256_coprocessor register port: turns one-shot commands into the exact write/read sequences the coprocessor expects.
- Commands are: reset coprocessor, load key+nonce, encrypt/decrypt one 128-bit block.
- Sits between a system master (valid/ready command/response) and the coprocessor's addr/data_in/write_en/data_out/interrupt pins.

---
 rtl/aes_cp_pkg.sv | 44 ++++
 rtl/aes_cp_host.sv | 229 ++++++++++++++++++++++
 tb/tb_aes_cp_host.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_cp_pkg.sv
// Shared constants and types for the aes256_coprocessor bus-initiator front end.
// Register map, status values, command opcodes, FSM states and word-select helpers.
package aes_cp_pkg;

  localparam logic [3:0] ADDR_STATUS = 4'd0;
  localparam logic [3:0] ADDR_NONCE0 = 4'd1;
  localparam logic [3:0] ADDR_KEY0   = 4'd5;
  localparam logic [3:0] ADDR_DIN    = 4'd13;
  localparam logic [3:0] ADDR_DOUT   = 4'd14;

  localparam int          STATUS_RUN_BIT = 0;
  localparam int          STATUS_RST_BIT = 1;
  localparam logic [31:0] STATUS_RUN     = 32'h0000_0001 << STATUS_RUN_BIT;
  localparam logic [31:0] STATUS_RST     = 32'h0000_0001 << STATUS_RST_BIT;
  localparam logic [31:0] STATUS_CLR     = 32'h0000_0000;

  localparam logic [1:0] OP_INIT     = 2'd0;
  localparam logic [1:0] OP_LOAD_KEY = 2'd1;
  localparam logic [1:0] OP_BLOCK    = 2'd2;
  localparam logic [1:0] OP_RSVD     = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT_RST = 4'd1,
    ST_INIT_CLR = 4'd2,
    ST_WR_NONCE = 4'd3,
    ST_WR_KEY   = 4'd4,
    ST_WR_DATA  = 4'd5,
    ST_WR_RUN   = 4'd6,
    ST_WAIT_INT = 4'd7,
    ST_RD_OUT   = 4'd8,
    ST_TO_RST   = 4'd9,
    ST_RESP     = 4'd10
  } state_e;

  function automatic logic [31:0] word128(input logic [127:0] v, input logic [1:0] idx);
    return v[{idx, 5'd0} +: 32];
  endfunction

  function automatic logic [31:0] word256(input logic [255:0] v, input logic [2:0] idx);
    return v[{idx, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/aes_cp_host.sv
// Sequences INIT / LOAD_KEY / BLOCK commands into aes256_coprocessor register accesses.
// Optional macro AES_CP_TIMEOUT_EN bounds the wait for cp_int to TIMEOUT_CYCLES.
module aes_cp_host
  import aes_cp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [255:0] cmd_key,
  input  logic [127:0] cmd_nonce,
  input  logic [127:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [3:0]   cp_addr,
  output logic [31:0]  cp_wdata,
  output logic         cp_we,
  input  logic [31:0]  cp_rdata,
  input  logic         cp_int
);

  state_e       state_r, state_s;
  logic [2:0]   cnt_r, cnt_s;
  logic [255:0] key_r, key_s;
  logic [127:0] nonce_r, nonce_s;
  logic [127:0] data_r, data_s;
  logic         accept_s;
  logic         cp_we_s;
  logic [3:0]   cp_addr_s;
  logic [31:0]  cp_wdata_s;
  logic [127:0] rsp_data_s;
  logic         rsp_err_s;

`ifdef AES_CP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;
  logic            to_hit_s;

  assign to_hit_s = (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter: zero outside WAIT_INT so it restarts on every entry.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (state_r != ST_WAIT_INT) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`endif

  assign accept_s = cmd_valid && (state_r == ST_IDLE);
  // Operands are taken straight from the command port in the accept cycle so
  // the first write can be registered out at T+1.
  assign key_s    = accept_s ? cmd_key   : key_r;
  assign nonce_s  = accept_s ? cmd_nonce : nonce_r;
  assign data_s   = accept_s ? cmd_data  : data_r;

  // Next-state and word-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_s = 3'd0;
          case (cmd_op)
            OP_INIT:     state_s = ST_INIT_RST;
            OP_LOAD_KEY: state_s = ST_WR_NONCE;
            OP_BLOCK:    state_s = ST_WR_DATA;
            default:     state_s = ST_RESP;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INIT_RST: state_s = ST_INIT_CLR;
      ST_INIT_CLR: state_s = ST_RESP;
      ST_WR_NONCE: begin
        if (cnt_r == 3'd3) begin
          state_s = ST_WR_KEY;
          cnt_s   = 3'd0;
        end else begin
          cnt_s   = cnt_r + 3'd1;
        end
      end
      ST_WR_KEY: begin
        if (cnt_r == 3'd7) begin
          state_s = ST_RESP;
          cnt_s   = 3'd0;
        end else begin
          cnt_s   = cnt_r + 3'd1;
        end
      end
      ST_WR_DATA: begin
        if (cnt_r == 3'd3) begin
          state_s = ST_WR_RUN;
          cnt_s   = 3'd0;
        end else begin
          cnt_s   = cnt_r + 3'd1;
        end
      end
      ST_WR_RUN: state_s = ST_WAIT_INT;
      ST_WAIT_INT: begin
        if (cp_int) begin
          state_s = ST_RD_OUT;
          cnt_s   = 3'd0;
        end
`ifdef AES_CP_TIMEOUT_EN
        else if (to_hit_s) begin
          state_s = ST_TO_RST;
        end
`endif
        else begin
          state_s = ST_WAIT_INT;
        end
      end
      ST_RD_OUT: begin
        if (cnt_r == 3'd3) begin
          state_s = ST_RESP;
          cnt_s   = 3'd0;
        end else begin
          cnt_s   = cnt_r + 3'd1;
        end
      end
      ST_TO_RST: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus decode for the upcoming cycle, registered below.
  always_comb begin
    cp_we_s    = 1'b0;
    cp_addr_s  = ADDR_STATUS;
    cp_wdata_s = 32'h0000_0000;
    case (state_s)
      ST_INIT_RST, ST_TO_RST: begin
        cp_we_s    = 1'b1;
        cp_wdata_s = STATUS_RST;
      end
      ST_INIT_CLR: begin
        cp_we_s    = 1'b1;
        cp_wdata_s = STATUS_CLR;
      end
      ST_WR_NONCE: begin
        cp_we_s    = 1'b1;
        cp_addr_s  = ADDR_NONCE0 + {2'b00, cnt_s[1:0]};
        cp_wdata_s = word128(nonce_s, cnt_s[1:0]);
      end
      ST_WR_KEY: begin
        cp_we_s    = 1'b1;
        cp_addr_s  = ADDR_KEY0 + {1'b0, cnt_s};
        cp_wdata_s = word256(key_s, cnt_s);
      end
      ST_WR_DATA: begin
        cp_we_s    = 1'b1;
        cp_addr_s  = ADDR_DIN;
        cp_wdata_s = word128(data_s, cnt_s[1:0]);
      end
      ST_WR_RUN: begin
        cp_we_s    = 1'b1;
        cp_wdata_s = STATUS_RUN;
      end
      ST_RD_OUT: cp_addr_s = ADDR_DOUT;
      default: cp_we_s = 1'b0;
    endcase
  end

  // Response payload: cleared on accept, filled word by word from the data-out port.
  always_comb begin
    rsp_data_s = rsp_data;
    rsp_err_s  = rsp_err;
    if (accept_s) begin
      rsp_data_s = 128'd0;
      rsp_err_s  = (cmd_op == OP_RSVD);
    end else if (state_r == ST_RD_OUT) begin
      rsp_data_s[{cnt_r[1:0], 5'd0} +: 32] = cp_rdata;
    end else if (state_r == ST_TO_RST) begin
      rsp_err_s  = 1'b1;
    end else begin
      rsp_err_s  = rsp_err;
    end
  end

  // State, operand and output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 3'd0;
      key_r     <= 256'd0;
      nonce_r   <= 128'd0;
      data_r    <= 128'd0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= 128'd0;
      rsp_err   <= 1'b0;
      cp_addr   <= 4'd0;
      cp_wdata  <= 32'd0;
      cp_we     <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      key_r     <= key_s;
      nonce_r   <= nonce_s;
      data_r    <= data_s;
      cmd_ready <= (state_s == ST_IDLE);
      rsp_valid <= (state_s == ST_RESP);
      rsp_data  <= rsp_data_s;
      rsp_err   <= rsp_err_s;
      cp_addr   <= cp_addr_s;
      cp_wdata  <= cp_wdata_s;
      cp_we     <= cp_we_s;
    end
  end

endmodule

// File: tb/tb_aes_cp_host.sv
// Randomized self-checking bench for aes_cp_host with a command-level reference model.
// Define AES_CP_TIMEOUT_EN to also exercise the cp_int timeout path (TIMEOUT_CYCLES=16).
module tb_aes_cp_host;
  import aes_cp_pkg::*;

`ifdef AES_CP_TIMEOUT_EN
  localparam int TO_CYC = 16;
`else
  localparam int TO_CYC = 1024;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready;
  logic [1:0]   cmd_op;
  logic [255:0] cmd_key;
  logic [127:0] cmd_nonce, cmd_data;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic [3:0]   cp_addr;
  logic [31:0]  cp_wdata, cp_rdata;
  logic         cp_we, cp_int;

  logic [31:0]  dout_w [4];
  logic [1:0]   dout_idx;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  aes_cp_host #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cp_addr(cp_addr), .cp_wdata(cp_wdata), .cp_we(cp_we),
    .cp_rdata(cp_rdata), .cp_int(cp_int)
  );

  // Coprocessor data-out port: each clock edge with addr=14 advances one word.
  assign cp_rdata = dout_w[dout_idx];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_idx <= 2'd0;
    else if (cp_addr == 4'd14) dout_idx <= dout_idx + 2'd1;
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // d: cycles from the run write to cp_int (negative = never); hold: cycles rsp_ready stays low.
  task automatic run_cmd(input logic [1:0] op, input logic [255:0] key, input logic [127:0] nonce,
                         input logic [127:0] data, input int d, input int hold);
    logic [43:0]  exp_q[$];
    logic [43:0]  got_q[$];
    int           exp_lat;
    logic         exp_err;
    logic [127:0] exp_data;
    int           n;
    int           lat;
    int           run_at;

    exp_err  = 1'b0;
    exp_data = 128'd0;
    case (op)
      2'd0: begin
        exp_q.push_back({8'd1, 4'd0, 32'h2});
        exp_q.push_back({8'd2, 4'd0, 32'h0});
        exp_lat = 3;
      end
      2'd1: begin
        for (int i = 0; i < 4; i++) exp_q.push_back({8'(1 + i), 4'(1 + i), nonce[32*i +: 32]});
        for (int j = 0; j < 8; j++) exp_q.push_back({8'(5 + j), 4'(5 + j), key[32*j +: 32]});
        exp_lat = 13;
      end
      2'd2: begin
        for (int i = 0; i < 4; i++) exp_q.push_back({8'(1 + i), 4'd13, data[32*i +: 32]});
        exp_q.push_back({8'd5, 4'd0, 32'h1});
        if (d < 0) begin
          exp_q.push_back({8'(6 + TO_CYC), 4'd0, 32'h2});
          exp_lat = 7 + TO_CYC;
          exp_err = 1'b1;
        end else begin
          exp_lat  = 5 + d + 5;
          exp_data = {dout_w[3], dout_w[2], dout_w[1], dout_w[0]};
        end
      end
      default: begin
        exp_lat = 1;
        exp_err = 1'b1;
      end
    endcase

    check_eq("idle_ready", 128'(cmd_ready), 128'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_nonce = nonce; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_key   = {8{$urandom()}};
    cmd_nonce = {4{$urandom()}};
    cmd_data  = {4{$urandom()}};
    n = 1; lat = -1; run_at = -1;
    while (lat < 0 && n < 400) begin
      cp_int = (op == 2'd2) && (n == 2 || (d >= 0 && run_at >= 0 && n == run_at + d));
      if (cp_we) got_q.push_back({8'(n), cp_addr, cp_wdata});
      else check_eq("wdata_idle", 128'(cp_wdata), 128'd0);
      if (cp_we && cp_addr == 4'd0 && cp_wdata == 32'h1) run_at = n;
      check_eq("busy_ready", 128'(cmd_ready), 128'd0);
      if (rsp_valid) lat = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
    cp_int = 1'b0;
    check_eq("rsp_seen", 128'(lat >= 0), 128'd1);
    if (lat >= 0) begin
      check_eq("rsp_latency", 128'(lat), 128'(exp_lat));
      check_eq("rsp_err", 128'(rsp_err), 128'(exp_err));
      check_eq("rsp_data", rsp_data, exp_data);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check_eq("hold_valid", 128'(rsp_valid), 128'd1);
        check_eq("hold_data", rsp_data, exp_data);
        check_eq("hold_err", 128'(rsp_err), 128'(exp_err));
        check_eq("hold_ready", 128'(cmd_ready), 128'd0);
        check_eq("hold_we", 128'(cp_we), 128'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check_eq("post_ready", 128'(cmd_ready), 128'd1);
      check_eq("post_valid", 128'(rsp_valid), 128'd0);
    end
    check_eq("write_count", 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq("write", 128'(got_q[i]), 128'(exp_q[i]));
  endtask

  initial begin
    logic [255:0] k;
    logic [127:0] nv, dv;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_key = 256'd0;
    cmd_nonce = 128'd0; cmd_data = 128'd0; rsp_ready = 1'b0; cp_int = 1'b0;
    for (int i = 0; i < 4; i++) dout_w[i] = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", 128'(cmd_ready), 128'd1);
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("rst_rsp_data", rsp_data, 128'd0);
    check_eq("rst_rsp_err", 128'(rsp_err), 128'd0);
    check_eq("rst_cp_bus", 128'({cp_we, cp_addr, cp_wdata}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(2'd0, 256'd0, 128'd0, 128'd0, 0, 0);
    run_cmd(2'd1, {256{1'b1}}, 128'd0, 128'd0, 0, 0);
    dout_w[0] = 32'hA; dout_w[1] = 32'hB; dout_w[2] = 32'hC; dout_w[3] = 32'hD;
    run_cmd(2'd2, 256'd0, 128'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 20, 0);
    dout_w[0] = $urandom(); dout_w[1] = $urandom(); dout_w[2] = $urandom(); dout_w[3] = $urandom();
    run_cmd(2'd2, 256'd0, 128'd0, {4{$urandom()}}, 1, 5);
    run_cmd(2'd3, 256'd0, 128'd0, 128'd0, 0, 2);

    // Reset pulse while the fourth key word is on the bus.
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_key = {8{$urandom()}}; cmd_nonce = {4{$urandom()}};
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("pre_rst_addr", 128'({cp_we, cp_addr}), 128'({1'b1, 4'd8}));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_we", 128'(cp_we), 128'd0);
    check_eq("mid_rst_valid", 128'(rsp_valid), 128'd0);
    check_eq("mid_rst_ready", 128'(cmd_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("after_rst_we", 128'(cp_we), 128'd0);
      check_eq("after_rst_ready", 128'(cmd_ready), 128'd1);
    end
    run_cmd(2'd0, 256'd0, 128'd0, 128'd0, 0, 1);

`ifdef AES_CP_TIMEOUT_EN
    run_cmd(2'd2, 256'd0, 128'd0, {4{$urandom()}}, -1, 1);
`endif

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
      for (int i = 0; i < 4; i++) begin
        nv[32*i +: 32] = $urandom();
        dv[32*i +: 32] = $urandom();
        dout_w[i]      = $urandom();
      end
      run_cmd(2'($urandom_range(0, 3)), k, nv, dv, $urandom_range(1, 30), $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
